// File: rtl/code_cmp.sv
// Code comparator: collects N digits, compares them with a stored code and
// locks out entry for LOCK_CYC cycles after MAX_FAIL consecutive mismatches.
module code_cmp #(
  parameter int                DW       = 4,
  parameter int                N        = 4,
  parameter int                MAX_FAIL = 3,
  parameter int                LOCK_CYC = 16,
  parameter logic [N*DW-1:0]   RST_CODE = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DW-1:0]                   din,
  input  logic                            din_valid,
  input  logic                            clr,
  input  logic                            set_code,
  input  logic [N*DW-1:0]                 code_in,
  output logic                            ready,
  output logic                            match,
  output logic                            mismatch,
  output logic                            locked,
  output logic [$clog2(N+1)-1:0]          digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CW = $clog2(N + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);

  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYC - 1);

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t            state_r, state_nx;
  logic [N*DW-1:0]   code_r, code_nx;
  logic [N*DW-1:0]   entered_r;
  logic [CW-1:0]     digit_cnt_r, digit_cnt_nx;
  logic [FW-1:0]     fail_r, fail_nx, fail_inc;
  logic [LW-1:0]     lock_r, lock_nx;
  logic              match_r, match_nx;
  logic              mismatch_r, mismatch_nx;
  logic              ready_r, locked_r;
  logic              dig_we;

  // Digit-wise equality: every digit must agree.
  function automatic logic codes_equal(input logic [N*DW-1:0] a,
                                       input logic [N*DW-1:0] b);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < N; i++) begin
      eq = eq & (a[i*DW +: DW] == b[i*DW +: DW]);
    end
    return eq;
  endfunction

  assign fail_inc = fail_r + FW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state_r;
    code_nx      = code_r;
    digit_cnt_nx = digit_cnt_r;
    fail_nx      = fail_r;
    lock_nx      = lock_r;
    match_nx     = 1'b0;
    mismatch_nx  = 1'b0;
    dig_we       = 1'b0;
    case (state_r)
      ENTRY: begin
        if (set_code) begin
          code_nx      = code_in;
          digit_cnt_nx = '0;
          fail_nx      = '0;
        end else if (clr) begin
          digit_cnt_nx = '0;
        end else if (din_valid) begin
          dig_we       = 1'b1;
          digit_cnt_nx = digit_cnt_r + CW'(1);
          if (digit_cnt_r == LAST_DIGIT) begin
            state_nx = CHECK;
          end else begin
            state_nx = ENTRY;
          end
        end else begin
          state_nx = ENTRY;
        end
      end
      CHECK: begin
        digit_cnt_nx = '0;
        if (codes_equal(entered_r, code_r)) begin
          match_nx = 1'b1;
          fail_nx  = '0;
          state_nx = ENTRY;
        end else if (fail_inc < FAIL_MAX) begin
          mismatch_nx = 1'b1;
          fail_nx     = fail_inc;
          state_nx    = ENTRY;
        end else begin
          mismatch_nx = 1'b1;
          fail_nx     = FAIL_MAX;
          lock_nx     = '0;
          state_nx    = LOCK;
        end
      end
      LOCK: begin
        // The cycle that carries the mismatch pulse counts as lock cycle 1.
        if (lock_r == LOCK_LAST) begin
          lock_nx  = '0;
          fail_nx  = '0;
          state_nx = ENTRY;
        end else begin
          lock_nx  = lock_r + LW'(1);
          state_nx = LOCK;
        end
      end
      default: begin
        state_nx     = ENTRY;
        digit_cnt_nx = '0;
        fail_nx      = '0;
        lock_nx      = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ENTRY;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_r      <= RST_CODE;
      entered_r   <= '0;
      digit_cnt_r <= '0;
      fail_r      <= '0;
      lock_r      <= '0;
      match_r     <= 1'b0;
      mismatch_r  <= 1'b0;
      ready_r     <= 1'b1;
      locked_r    <= 1'b0;
    end else begin
      code_r      <= code_nx;
      digit_cnt_r <= digit_cnt_nx;
      fail_r      <= fail_nx;
      lock_r      <= lock_nx;
      match_r     <= match_nx;
      mismatch_r  <= mismatch_nx;
      ready_r     <= (state_nx == ENTRY);
      locked_r    <= (state_nx == LOCK);
      for (int i = 0; i < N; i++) begin
        if (dig_we && (digit_cnt_r == CW'(i))) begin
          entered_r[i*DW +: DW] <= din;
        end
      end
    end
  end

  assign ready     = ready_r;
  assign match     = match_r;
  assign mismatch  = mismatch_r;
  assign locked    = locked_r;
  assign digit_cnt = digit_cnt_r;
  assign fail_cnt  = fail_r;

endmodule

// File: tb/tb_code_cmp.sv
// Directed self-checking bench for code_cmp at default parameters.
module tb_code_cmp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  din;
  logic        din_valid;
  logic        clr;
  logic        set_code;
  logic [15:0] code_in;
  logic        ready, match, mismatch, locked;
  logic [2:0]  digit_cnt;
  logic [1:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  code_cmp dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
    .set_code(set_code), .code_in(code_in), .ready(ready), .match(match),
    .mismatch(mismatch), .locked(locked), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic digit(input logic [3:0] d);
    din = d; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Enter four digits, digit 0 first, and step into the CHECK cycle.
  task automatic enter_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 4; i++) digit(v[i*4 +: 4]);
  endtask

  initial begin
    rst_n = 1'b0; din = 4'd0; din_valid = 1'b0; clr = 1'b0;
    set_code = 1'b0; code_in = 16'h0000;
    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_digit_cnt", {29'd0, digit_cnt}, 32'd0);
    chk("rst_fail_cnt", {30'd0, fail_cnt}, 32'd0);
    rst_n = 1'b1;

    // Load 4321 and enter it back.
    set_code = 1'b1; code_in = 16'h4321;
    tick();
    set_code = 1'b0;
    digit(4'd1); digit(4'd2); digit(4'd3);
    chk("load_cnt3", {29'd0, digit_cnt}, 32'd3);
    digit(4'd4);
    chk("check_ready", {31'd0, ready}, 32'd0);
    chk("check_match_early", {31'd0, match}, 32'd0);
    tick();
    chk("load_match", {31'd0, match}, 32'd1);
    chk("load_no_mismatch", {31'd0, mismatch}, 32'd0);
    chk("load_fail0", {30'd0, fail_cnt}, 32'd0);
    chk("load_cnt0", {29'd0, digit_cnt}, 32'd0);
    tick();
    chk("load_match_one_cycle", {31'd0, match}, 32'd0);
    chk("load_ready_after", {31'd0, ready}, 32'd1);

    // Three wrong entries lead to lockout.
    for (int k = 1; k <= 3; k++) begin
      enter_code(16'h5321);
      tick();
      chk("lk_mismatch", {31'd0, mismatch}, 32'd1);
      chk("lk_match", {31'd0, match}, 32'd0);
      chk("lk_fail_cnt", {30'd0, fail_cnt}, k);
      chk("lk_locked", {31'd0, locked}, (k == 3) ? 32'd1 : 32'd0);
      chk("lk_ready", {31'd0, ready}, (k == 3) ? 32'd0 : 32'd1);
    end
    din = 4'd1; din_valid = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      tick();
      chk("lk_hold_locked", {31'd0, locked}, 32'd1);
      chk("lk_hold_cnt", {29'd0, digit_cnt}, 32'd0);
      chk("lk_hold_mismatch", {31'd0, mismatch}, 32'd0);
    end
    din_valid = 1'b0;
    tick();
    chk("lk_end_locked", {31'd0, locked}, 32'd0);
    chk("lk_end_ready", {31'd0, ready}, 32'd1);
    chk("lk_end_fail", {30'd0, fail_cnt}, 32'd0);

    // One mismatch, then clear and priority behaviour.
    enter_code(16'h0000);
    tick();
    chk("pr_mismatch", {31'd0, mismatch}, 32'd1);
    digit(4'd1); digit(4'd2);
    chk("pr_cnt2", {29'd0, digit_cnt}, 32'd2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("pr_clr_cnt", {29'd0, digit_cnt}, 32'd0);
    chk("pr_clr_keeps_fail", {30'd0, fail_cnt}, 32'd1);
    digit(4'd1);
    clr = 1'b1; din = 4'd2; din_valid = 1'b1; tick(); clr = 1'b0; din_valid = 1'b0;
    chk("pr_clr_over_din", {29'd0, digit_cnt}, 32'd0);
    digit(4'd5);
    set_code = 1'b1; clr = 1'b1; code_in = 16'h9876;
    tick();
    set_code = 1'b0; clr = 1'b0;
    chk("pr_set_cnt", {29'd0, digit_cnt}, 32'd0);
    chk("pr_set_fail", {30'd0, fail_cnt}, 32'd0);

    // Gapped entry of the new code 9876 (digits 6,7,8,9).
    digit(4'd6);
    digit(4'd7);
    for (int i = 0; i < 3; i++) tick();
    digit(4'd8);
    for (int i = 0; i < 7; i++) tick();
    chk("gap_cnt3", {29'd0, digit_cnt}, 32'd3);
    digit(4'd9);
    din = 4'd6; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("gap_match", {31'd0, match}, 32'd1);
    chk("gap_cnt0", {29'd0, digit_cnt}, 32'd0);
    tick();
    chk("gap_cnt_stays0", {29'd0, digit_cnt}, 32'd0);
    chk("gap_match_off", {31'd0, match}, 32'd0);

    // Reset in the middle of a lockout restores RST_CODE.
    for (int k = 1; k <= 3; k++) begin
      enter_code(16'h1111);
      tick();
    end
    chk("rl_locked", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("rl_locked5", {31'd0, locked}, 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rl_unlocked", {31'd0, locked}, 32'd0);
    chk("rl_ready", {31'd0, ready}, 32'd1);
    chk("rl_fail", {30'd0, fail_cnt}, 32'd0);
    enter_code(16'h0000);
    tick();
    chk("rl_match", {31'd0, match}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
